// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit adder built from one 4-bit ripple slice
// reused over WIDTH/4 cycles, least-significant nibble first. Rev 1.0
`default_nettype none

module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             CO
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and at least 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  logic [NIB-1:0][3:0] a_q;
  logic [NIB-1:0][3:0] b_q;
  logic [NIB-1:0][3:0] sum_q;
  logic [NIB-1:0][3:0] sum_next;
  logic                carry;
  logic [IW-1:0]       idx;
  logic [3:0]          slice_s;
  logic                slice_co;

  ripple_carry_adder_4bit u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  // Completed sum including the nibble being produced this cycle, so the
  // last RUN edge can publish S without an extra cycle.
  always_comb begin
    sum_next      = sum_q;
    sum_next[idx] = slice_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      S     <= '0;
      CO    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            carry <= CI;
            idx   <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end else begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q <= sum_next;
          carry <= slice_co;
          if (idx == LAST) begin
            S     <= sum_next;
            CO    <= slice_co;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: vector table, corner sequences and random
// operations against an arithmetic reference for the nibble-serial adder.
`default_nettype none

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        CI = 1'b0;
  logic        busy, done, CO;
  logic [15:0] S;

  logic       start4 = 1'b0;
  logic [3:0] A4 = '0, B4 = '0;
  logic       CI4 = 1'b0;
  logic       busy4, done4, CO4;
  logic [3:0] S4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .CI(CI),
    .busy(busy), .done(done), .S(S), .CO(CO)
  );

  nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .CI(CI4),
    .busy(busy4), .done(done4), .S(S4), .CO(CO4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic [15:0] s;
    logic        co;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launch one operation from idle; returns at the negedge where done is seen
  // (or after the cycle budget), with lat = edges from accept to completion.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                       input bit scribble, output logic [15:0] s_o,
                       output logic co_o, output int lat);
    @(negedge clk);
    A = a; B = b; CI = ci; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (scribble) begin
      A  = 16'($urandom);
      B  = 16'($urandom);
      CI = 1'($urandom);
    end
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s_o  = S;
    co_o = CO;
  endtask

  initial begin
    logic [15:0] s_got, s1, s2, ra, rb;
    logic        co_got, co1, co2, rci;
    logic [16:0] ref_sum;
    int          lat, ndone, cyc, first, second, bad;

    tbl[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    tbl[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[4] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0};
    tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    tbl[6] = '{16'h1111, 16'h1111, 1'b0, 16'h2222, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_S", 32'(S), 0);
    check("reset_CO", 32'(CO), 0);
    check("reset_S4", 32'(S4), 0);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 7; i++) begin
      run16(tbl[i].a, tbl[i].b, tbl[i].ci, 1'b0, s_got, co_got, lat);
      check($sformatf("tbl%0d_S", i), 32'(s_got), 32'(tbl[i].s));
      check($sformatf("tbl%0d_CO", i), 32'(co_got), 32'(tbl[i].co));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 4);
      @(negedge clk);
      check($sformatf("tbl%0d_done_width", i), {30'd0, busy, done}, 0);
    end

    // Start re-pulsed and operands changed mid-RUN must be ignored
    @(negedge clk);
    A = 16'h0000; B = 16'h0000; CI = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = 16'hAAAA; B = 16'hAAAA;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 2;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("ignore_S", 32'(S), 32'h0001);
    check("ignore_CO", 32'(CO), 0);
    check("ignore_latency", 32'(lat), 4);
    repeat (3) @(negedge clk);
    check("ignore_no_second_op", {30'd0, busy, done}, 0);

    // Back-to-back with start held high
    @(negedge clk);
    A = 16'h00F0; B = 16'h0010; CI = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    A = 16'h8000; B = 16'h8000;
    ndone = 0; cyc = 0; bad = 0; first = 0; second = 0;
    s1 = '0; s2 = '0; co1 = 1'b0; co2 = 1'b0;
    while (ndone < 2 && cyc < 40) begin
      if (busy == done) bad++;
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          first = cyc; s1 = S; co1 = CO;
        end else begin
          second = cyc; s2 = S; co2 = CO; start = 1'b0;
        end
      end
      if (ndone < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("b2b_done_count", 32'(ndone), 2);
    check("b2b_spacing", 32'(second - first), 5);
    check("b2b_busy_vs_done", 32'(bad), 0);
    check("b2b_S1", 32'(s1), 32'h0100);
    check("b2b_CO1", 32'(co1), 0);
    check("b2b_S2", 32'(s2), 32'h0000);
    check("b2b_CO2", 32'(co2), 1);

    // Asynchronous reset in the second RUN cycle
    @(negedge clk);
    A = 16'h1111; B = 16'h1111; CI = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("arst_busy_before", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_S", 32'(S), 0);
    check("arst_CO", 32'(CO), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) bad++;
    end
    check("arst_no_done", 32'(bad), 0);
    run16(16'h1111, 16'h1111, 1'b0, 1'b0, s_got, co_got, lat);
    check("arst_fresh_S", 32'(s_got), 32'h2222);
    check("arst_fresh_CO", 32'(co_got), 0);

    // WIDTH=4: single-cycle RUN
    @(negedge clk);
    A4 = 4'h9; B4 = 4'h8; CI4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    check("w4_busy", {30'd0, busy4, done4}, 32'h2);
    @(negedge clk);
    check("w4_done", {30'd0, busy4, done4}, 32'h1);
    check("w4_S", 32'(S4), 32'h2);
    check("w4_CO", 32'(CO4), 1);

    // Random operations against the arithmetic reference
    for (int i = 0; i < 30; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rci = 1'($urandom);
      ref_sum = 17'(ra) + 17'(rb) + 17'(rci);
      run16(ra, rb, rci, 1'b1, s_got, co_got, lat);
      check($sformatf("rnd%0d_S", i), 32'(s_got), 32'(ref_sum[15:0]));
      check($sformatf("rnd%0d_CO", i), 32'(co_got), 32'(ref_sum[16]));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
